// File: rtl/trace_checker.sv
// Golden-trace checker: compares each processor commit event against a record
// read combinationally from a trace ROM and reports pass/fail, count and first error.
module trace_checker #(
  parameter int ADDR_W  = 10,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              c_valid,
  input  logic [15:0]       c_pc,
  input  logic              c_regwrite,
  input  logic [2:0]        c_wreg,
  input  logic [15:0]       c_wdata,
  input  logic              c_memread,
  input  logic              c_memwrite,
  input  logic [15:0]       c_memaddr,
  input  logic [15:0]       c_memdata,
  input  logic              c_halt,
  output logic [ADDR_W-1:0] exp_addr,
  input  logic [71:0]       exp_rdata,
  output logic              done,
  output logic              pass,
  output logic [CNT_W-1:0]  inst_count,
  output logic [CNT_W-1:0]  mismatch_idx,
  output logic [7:0]        err_mask
);

  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  typedef enum logic [1:0] {IDLE, RUN, PASS, FAIL} state_t;

  state_t            state, stateNxt;
  logic [ADDR_W-1:0] expAddr, expAddrNxt;
  logic [CNT_W-1:0]  instCount, instCountNxt;
  logic [CNT_W-1:0]  mismatchIdx, mismatchIdxNxt;
  logic [7:0]        errMask, errMaskNxt;
  logic [TMR_W-1:0]  timer, timerNxt;
  logic [7:0]        missMask;

  // Field compare of the current commit against the golden record; an absent
  // record (rec_valid=0) masks every field check.
  always_comb begin
    missMask = '0;
    if (!exp_rdata[71]) begin
      missMask[6] = 1'b1;
    end else begin
      missMask[0] = (c_pc != exp_rdata[15:0]);
      missMask[1] = ({c_regwrite, c_memwrite, c_memread, c_halt} !=
                     {exp_rdata[67], exp_rdata[68], exp_rdata[69], exp_rdata[70]});
      missMask[2] = exp_rdata[67] && (c_wreg != exp_rdata[66:64]);
      missMask[3] = exp_rdata[67] && (c_wdata != exp_rdata[31:16]);
      missMask[4] = (exp_rdata[69] || exp_rdata[68]) && (c_memaddr != exp_rdata[47:32]);
      missMask[5] = exp_rdata[68] && (c_memdata != exp_rdata[63:48]);
    end
  end

  always_comb begin
    stateNxt       = state;
    expAddrNxt     = expAddr;
    instCountNxt   = instCount;
    mismatchIdxNxt = mismatchIdx;
    errMaskNxt     = errMask;
    timerNxt       = timer;
    case (state)
      RUN: begin
        if (c_valid) begin
          timerNxt = '0;
          if (missMask != 8'h00) begin
            stateNxt       = FAIL;
            errMaskNxt     = missMask;
            mismatchIdxNxt = CNT_W'(expAddr);
          end else begin
            instCountNxt = instCount + CNT_W'(1);
            if (exp_rdata[70]) begin
              stateNxt = PASS;
            end else if (expAddr == LAST_ADDR) begin
              // Trace ran off the end of the ROM without a halt; no wrap.
              stateNxt       = FAIL;
              errMaskNxt     = 8'h40;
              mismatchIdxNxt = CNT_W'(expAddr) + CNT_W'(1);
            end else begin
              expAddrNxt = expAddr + ADDR_W'(1);
            end
          end
        end else if (timer == TMR_W'(TIMEOUT - 1)) begin
          stateNxt       = FAIL;
          errMaskNxt     = 8'h80;
          mismatchIdxNxt = CNT_W'(expAddr);
        end else begin
          timerNxt = timer + TMR_W'(1);
        end
      end
      default: begin
        if (start) begin
          stateNxt       = RUN;
          expAddrNxt     = '0;
          instCountNxt   = '0;
          mismatchIdxNxt = '0;
          errMaskNxt     = '0;
          timerNxt       = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      expAddr     <= '0;
      instCount   <= '0;
      mismatchIdx <= '0;
      errMask     <= '0;
      timer       <= '0;
    end else begin
      state       <= stateNxt;
      expAddr     <= expAddrNxt;
      instCount   <= instCountNxt;
      mismatchIdx <= mismatchIdxNxt;
      errMask     <= errMaskNxt;
      timer       <= timerNxt;
    end
  end

  assign exp_addr     = expAddr;
  assign done         = (state == PASS) || (state == FAIL);
  assign pass         = (state == PASS);
  assign inst_count   = instCount;
  assign mismatch_idx = mismatchIdx;
  assign err_mask     = errMask;

endmodule

// File: tb/tb_trace_checker.sv
// Bench for trace_checker: single-commit vector table, hand-written multi-cycle
// sequences and randomized traces checked against a transaction-level model.
module tb_trace_checker;

  localparam int ADDR_W  = 3;
  localparam int CNT_W   = 16;
  localparam int TIMEOUT = 8;
  localparam int DEPTH   = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst_n, start, c_valid;
  logic [15:0]       c_pc, c_wdata, c_memaddr, c_memdata;
  logic              c_regwrite, c_memread, c_memwrite, c_halt;
  logic [2:0]        c_wreg;
  logic [ADDR_W-1:0] exp_addr;
  logic [71:0]       exp_rdata;
  logic              done, pass;
  logic [CNT_W-1:0]  inst_count, mismatch_idx;
  logic [7:0]        err_mask;

  logic [71:0] rom [0:DEPTH-1];
  assign exp_rdata = rom[exp_addr];

  int nTests = 0;
  int nFail  = 0;

  always #5 clk = ~clk;

  trace_checker #(.ADDR_W(ADDR_W), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .c_valid(c_valid),
    .c_pc(c_pc), .c_regwrite(c_regwrite), .c_wreg(c_wreg), .c_wdata(c_wdata),
    .c_memread(c_memread), .c_memwrite(c_memwrite), .c_memaddr(c_memaddr),
    .c_memdata(c_memdata), .c_halt(c_halt), .exp_addr(exp_addr),
    .exp_rdata(exp_rdata), .done(done), .pass(pass), .inst_count(inst_count),
    .mismatch_idx(mismatch_idx), .err_mask(err_mask)
  );

  typedef struct packed {
    logic [15:0] pc;
    logic        rw;
    logic [2:0]  wreg;
    logic [15:0] wdata;
    logic        mr;
    logic        mw;
    logic [15:0] maddr;
    logic [15:0] mdata;
    logic        halt;
  } commit_t;

  typedef struct {
    string       name;
    logic [71:0] rec;
    commit_t     c;
    logic [7:0]  expMask;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [71:0] mkRec(logic v, logic h, logic mr, logic mw, logic rw,
                                        logic [2:0] wreg, logic [15:0] mdata,
                                        logic [15:0] maddr, logic [15:0] wdata,
                                        logic [15:0] pc);
    return {v, h, mr, mw, rw, wreg, mdata, maddr, wdata, pc};
  endfunction

  function automatic commit_t fromRec(logic [71:0] r);
    commit_t c;
    c.pc = r[15:0];  c.wdata = r[31:16]; c.maddr = r[47:32]; c.mdata = r[63:48];
    c.wreg = r[66:64]; c.rw = r[67]; c.mw = r[68]; c.mr = r[69]; c.halt = r[70];
    return c;
  endfunction

  // Reference: which fields of a commit disagree with the record it retires against.
  function automatic logic [7:0] modelMask(commit_t c, logic [71:0] r);
    commit_t e;
    logic [7:0] m;
    if (!r[71]) return 8'h40;
    e = fromRec(r);
    m = 8'h00;
    if (c.pc != e.pc) m |= 8'h01;
    if (c.rw != e.rw || c.mw != e.mw || c.mr != e.mr || c.halt != e.halt) m |= 8'h02;
    if (e.rw && c.wreg != e.wreg) m |= 8'h04;
    if (e.rw && c.wdata != e.wdata) m |= 8'h08;
    if ((e.mr || e.mw) && c.maddr != e.maddr) m |= 8'h10;
    if (e.mw && c.mdata != e.mdata) m |= 8'h20;
    return m;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chkAll(string nm, logic d, logic p, int cnt, int idx, logic [7:0] m);
    chk({nm, ".done"}, 32'(done), 32'(d));
    chk({nm, ".pass"}, 32'(pass), 32'(p));
    chk({nm, ".count"}, 32'(inst_count), 32'(cnt));
    chk({nm, ".idx"}, 32'(mismatch_idx), 32'(idx));
    chk({nm, ".mask"}, 32'(err_mask), 32'(m));
  endtask

  task automatic setCommit(commit_t c);
    c_pc = c.pc; c_regwrite = c.rw; c_wreg = c.wreg; c_wdata = c.wdata;
    c_memread = c.mr; c_memwrite = c.mw; c_memaddr = c.maddr; c_memdata = c.mdata;
    c_halt = c.halt;
  endtask

  task automatic drive(commit_t c);
    setCommit(c);
    c_valid = 1'b1;
    @(posedge clk); #1;
    c_valid = 1'b0;
  endtask

  task automatic idle(int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulseStart();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic clearRom();
    for (int i = 0; i < DEPTH; i++) rom[i] = '0;
  endtask

  task automatic loadDemo();
    clearRom();
    rom[0] = mkRec(1, 0, 0, 0, 1, 3'd1, 16'h0000, 16'h0000, 16'h0005, 16'h0000);
    rom[1] = mkRec(1, 0, 0, 1, 0, 3'd0, 16'h0005, 16'h0010, 16'h0000, 16'h0002);
    rom[2] = mkRec(1, 1, 0, 0, 0, 3'd0, 16'h0000, 16'h0000, 16'h0000, 16'h0004);
  endtask

  task automatic addVec(string nm, logic [71:0] r, commit_t c, logic [7:0] m);
    vec_t v;
    v.name = nm; v.rec = r; v.c = c; v.expMask = m;
    vecs.push_back(v);
  endtask

  initial begin
    logic [71:0] ld, st, alu, nop, ldInv;
    commit_t c;
    commit_t cs [0:DEPTH-1];
    int gaps [0:DEPTH-1];
    int len;
    logic mFail, mPass;
    int mCnt, mIdx;
    logic [7:0] mMask, m;

    rst_n = 1'b0; start = 1'b0; c_valid = 1'b0;
    c = '0;
    setCommit(c);
    clearRom();
    #2;
    chk("reset.addr", 32'(exp_addr), 0);
    chkAll("reset", 0, 0, 0, 0, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single-commit vectors; every record halts, so a clean match ends in PASS.
    ld    = mkRec(1, 1, 1, 0, 1, 3'd2, 16'h0000, 16'h0040, 16'h1234, 16'h0100);
    st    = mkRec(1, 1, 0, 1, 0, 3'd0, 16'hBEEF, 16'h0080, 16'h0000, 16'h0200);
    alu   = mkRec(1, 1, 0, 0, 1, 3'd5, 16'h0000, 16'h0000, 16'h00AA, 16'h0300);
    nop   = mkRec(1, 1, 0, 0, 0, 3'd0, 16'h0000, 16'h0000, 16'h0000, 16'h0400);
    ldInv = mkRec(0, 1, 1, 0, 1, 3'd2, 16'h0000, 16'h0040, 16'h1234, 16'h0100);
    c = fromRec(ld);                                     addVec("ld_ok", ld, c, 8'h00);
    c = fromRec(ld); c.rw = 1'b0;                        addVec("ld_norw", ld, c, 8'h02);
    c = fromRec(ld); c.pc ^= 16'h0001;                   addVec("ld_pc", ld, c, 8'h01);
    c = fromRec(ld); c.wreg = 3'd3;                      addVec("ld_wreg", ld, c, 8'h04);
    c = fromRec(ld); c.wdata ^= 16'h00FF;                addVec("ld_wdata", ld, c, 8'h08);
    c = fromRec(ld); c.wreg = 3'd3; c.wdata = 16'h0;     addVec("ld_wreg_wdata", ld, c, 8'h0C);
    c = fromRec(ld); c.maddr = 16'h0044;                 addVec("ld_maddr", ld, c, 8'h10);
    c = fromRec(ld); c.mdata = 16'h5555;                 addVec("ld_mdata_dc", ld, c, 8'h00);
    c = fromRec(st); c.mdata = 16'hBEEE;                 addVec("st_mdata", st, c, 8'h20);
    c = fromRec(st); c.maddr = 16'h0; c.mdata = 16'h0;   addVec("st_maddr_mdata", st, c, 8'h30);
    c = fromRec(st); c.wreg = 3'd7; c.wdata = 16'h9999;  addVec("st_wdata_dc", st, c, 8'h00);
    c = fromRec(nop); c.wdata = 16'h1; c.maddr = 16'h2;  addVec("nop_dc", nop, c, 8'h00);
    c = fromRec(alu); c.halt = 1'b0;                     addVec("alu_halt", alu, c, 8'h02);
    c = fromRec(alu); c.pc = 16'h0000; c.wdata = 16'h0;  addVec("alu_pc_wdata", alu, c, 8'h09);
    c = fromRec(ld); c.pc = 16'hFFFF;                    addVec("rec_invalid", ldInv, c, 8'h40);

    foreach (vecs[i]) begin
      clearRom();
      rom[0] = vecs[i].rec;
      pulseStart();
      drive(vecs[i].c);
      chkAll(vecs[i].name, 1, vecs[i].expMask == 0, (vecs[i].expMask == 0) ? 1 : 0, 0,
             vecs[i].expMask);
    end

    // Golden 3-record trace, clean run, then a commit after PASS is ignored.
    loadDemo();
    pulseStart();
    chkAll("demo_start", 0, 0, 0, 0, 8'h00);
    for (int k = 0; k < 3; k++) drive(fromRec(rom[k]));
    chkAll("demo_pass", 1, 1, 3, 0, 8'h00);
    drive(fromRec(rom[0]));
    chkAll("demo_frozen", 1, 1, 3, 0, 8'h00);

    // Store data wrong on commit 2.
    pulseStart();
    drive(fromRec(rom[0]));
    c = fromRec(rom[1]); c.mdata = 16'h0006;
    drive(c);
    chkAll("demo_mdata", 1, 0, 1, 1, 8'h20);

    // Start during RUN is ignored and its commit still retires.
    pulseStart();
    drive(fromRec(rom[0]));
    start = 1'b1;
    drive(fromRec(rom[1]));
    start = 1'b0;
    chk("start_in_run.addr", 32'(exp_addr), 2);
    chk("start_in_run.count", 32'(inst_count), 2);
    drive(fromRec(rom[2]));
    chkAll("start_in_run_end", 1, 1, 3, 0, 8'h00);

    // End-of-trace marker at record 1.
    loadDemo();
    rom[1] = '0;
    pulseStart();
    drive(fromRec(rom[0]));
    c = fromRec(rom[0]); c.pc = 16'h0002;
    drive(c);
    chkAll("trace_end", 1, 0, 1, 1, 8'h40);

    // Timeout: 7 idle cycles are tolerated, the 8th fails.
    pulseStart();
    idle(TIMEOUT - 1);
    chk("timeout_pre.done", 32'(done), 0);
    idle(1);
    chkAll("timeout", 1, 0, 0, 0, 8'h80);

    // Whole ROM matches with no halt: runs off the end.
    for (int k = 0; k < DEPTH; k++)
      rom[k] = mkRec(1, 0, 0, 0, 1, 3'(k), 16'h0, 16'h0, 16'(k * 3), 16'(k * 2));
    pulseStart();
    for (int k = 0; k < DEPTH; k++) drive(fromRec(rom[k]));
    chkAll("rom_end", 1, 0, DEPTH, DEPTH, 8'h40);

    // Asynchronous reset mid-run, then start+commit in IDLE, then a full trace.
    loadDemo();
    pulseStart();
    drive(fromRec(rom[0]));
    drive(fromRec(rom[1]));
    rst_n = 1'b0;
    #1;
    chk("midreset.addr", 32'(exp_addr), 0);
    chkAll("midreset", 0, 0, 0, 0, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    start = 1'b1;
    drive(fromRec(rom[0]));
    start = 1'b0;
    chk("idle_start_valid.count", 32'(inst_count), 0);
    chk("idle_start_valid.addr", 32'(exp_addr), 0);
    for (int k = 0; k < 3; k++) drive(fromRec(rom[k]));
    chkAll("after_reset", 1, 1, 3, 0, 8'h00);

    // Randomized traces against the transaction-level model.
    for (int t = 0; t < 40; t++) begin
      clearRom();
      len = $urandom_range(1, DEPTH - 1);
      for (int k = 0; k < len; k++) begin
        rom[k] = {1'b1, (k == len - 1) ? 1'b1 : 1'b0, 3'($urandom_range(0, 7)),
                  3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom), 16'($urandom),
                  16'($urandom)};
        c = fromRec(rom[k]);
        if ($urandom_range(0, 4) == 0) begin
          case ($urandom_range(0, 8))
            0: c.pc    ^= 16'h1 << $urandom_range(0, 15);
            1: c.rw    = ~c.rw;
            2: c.wreg  ^= 3'h1 << $urandom_range(0, 2);
            3: c.wdata ^= 16'h1 << $urandom_range(0, 15);
            4: c.mr    = ~c.mr;
            5: c.mw    = ~c.mw;
            6: c.maddr ^= 16'h1 << $urandom_range(0, 15);
            7: c.mdata ^= 16'h1 << $urandom_range(0, 15);
            default: c.halt = ~c.halt;
          endcase
        end
        cs[k] = c;
        gaps[k] = ($urandom_range(0, 9) == 0) ? TIMEOUT : $urandom_range(0, 3);
      end
      mFail = 1'b0; mPass = 1'b0; mCnt = 0; mIdx = 0; mMask = 8'h00;
      for (int k = 0; k < len && !mFail && !mPass; k++) begin
        if (gaps[k] >= TIMEOUT) begin
          mFail = 1'b1; mMask = 8'h80; mIdx = k;
        end else begin
          m = modelMask(cs[k], rom[k]);
          if (m != 0) begin
            mFail = 1'b1; mMask = m; mIdx = k;
          end else begin
            mCnt++;
            if (cs[k].halt) mPass = 1'b1;
          end
        end
      end
      pulseStart();
      for (int k = 0; k < len; k++) begin
        idle(gaps[k]);
        drive(cs[k]);
      end
      idle(1);
      chkAll($sformatf("rand%0d", t), 1, mPass, mCnt, mIdx, mMask);
    end

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
